// File: rtl/lifo_port_ctrl_if.sv
// Port bundle for lifo_port_ctrl: push stream, pop stream, flush/busy,
// LIFO request/response wires and the optional statistics counters.
// The controller uses the slave modport; the surrounding logic uses master.
interface lifo_port_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              flush;
    logic              busy;
    logic              lifo_w_req;
    logic [DATA_W-1:0] lifo_w_data;
    logic              lifo_r_req;
    logic [DATA_W-1:0] lifo_r_data;
    logic              lifo_empty;
    logic              lifo_full;
    logic [STAT_W-1:0] push_cnt;
    logic [STAT_W-1:0] pop_cnt;

    modport slave (
        input  s_valid, s_data, m_ready, flush, lifo_r_data, lifo_empty, lifo_full,
        output s_ready, m_valid, m_data, busy, lifo_w_req, lifo_w_data, lifo_r_req,
               push_cnt, pop_cnt
    );

    modport master (
        output s_valid, s_data, m_ready, flush, lifo_r_data, lifo_empty, lifo_full,
        input  s_ready, m_valid, m_data, busy, lifo_w_req, lifo_w_data, lifo_r_req,
               push_cnt, pop_cnt
    );
endinterface

// File: rtl/lifo_port_ctrl.sv
// lifo_port_ctrl: turns a valid/ready push stream into LIFO writes and drains
// the LIFO into a registered valid/ready pop stream. A free output register
// takes the incoming word directly (bypass), so the LIFO never sees a write
// and a read in the same cycle. flush discards the output register and pops
// the LIFO until it reports empty.
// Optional feature macro: LIFO_PORT_CTRL_STATS_EN (saturating push/pop counters).
module lifo_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic            clk,
    input  logic            nrst,
    lifo_port_ctrl_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [STAT_W-1:0] stat_t;

    state_t            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              busy_q, busy_d;

    logic              load;
    logic              s_ready_c;
    logic              w_req_c;
    logic              r_req_c;
    logic              push_fire;
    logic              pop_fire;

    // Next-state, output-register load and LIFO request decode
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;
        s_ready_c = 1'b0;
        w_req_c   = 1'b0;
        r_req_c   = 1'b0;
        pop_fire  = 1'b0;
        load      = ~m_valid_q | bus.m_ready;

        unique case (state_q)
            RUN: begin
                if (bus.flush) begin
                    // Handshakes in the flush cycle are dropped on both sides.
                    state_d   = DRAIN;
                    m_valid_d = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    pop_fire = m_valid_q & bus.m_ready;
                    if (load) begin
                        s_ready_c = 1'b1;
                        if (bus.s_valid) begin
                            // Newest word is top of stack: hand it straight out.
                            m_data_d  = bus.s_data;
                            m_valid_d = 1'b1;
                        end else if (!bus.lifo_empty) begin
                            r_req_c   = 1'b1;
                            m_data_d  = bus.lifo_r_data;
                            m_valid_d = 1'b1;
                        end else begin
                            m_valid_d = 1'b0;
                        end
                    end else begin
                        // Output register is committed; park the word in the LIFO.
                        s_ready_c = ~bus.lifo_full;
                        w_req_c   = bus.s_valid & ~bus.lifo_full;
                    end
                end
            end
            DRAIN: begin
                m_valid_d = 1'b0;
                r_req_c   = ~bus.lifo_empty;
                if (bus.lifo_empty) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = RUN;
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Keep the LIFO and the source quiet while reset is held.
        if (!nrst) begin
            s_ready_c = 1'b0;
            w_req_c   = 1'b0;
            r_req_c   = 1'b0;
            pop_fire  = 1'b0;
        end
    end

    assign push_fire = bus.s_valid & s_ready_c;

    // State and output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= RUN;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.busy        = busy_q;
    assign bus.lifo_w_req  = w_req_c;
    assign bus.lifo_w_data = bus.s_data;
    assign bus.lifo_r_req  = r_req_c;

`ifdef LIFO_PORT_CTRL_STATS_EN
    stat_t push_cnt_q, push_cnt_d;
    stat_t pop_cnt_q, pop_cnt_d;

    function automatic stat_t sat_inc(input stat_t v, input logic en);
        if (en && (v != '1)) begin
            return v + stat_t'(1);
        end
        return v;
    endfunction

    // Saturating statistics next values
    always_comb begin
        push_cnt_d = sat_inc(push_cnt_q, push_fire);
        pop_cnt_d  = sat_inc(pop_cnt_q, pop_fire);
    end

    // Statistics counters, cleared only by reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    assign bus.push_cnt = push_cnt_q;
    assign bus.pop_cnt  = pop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = push_fire ^ pop_fire;
    assign bus.push_cnt = stat_t'(0);
    assign bus.pop_cnt  = stat_t'(0);
`endif

endmodule

// File: tb/tb_lifo_port_ctrl.sv
// Directed bench for lifo_port_ctrl with a behavioural 8-deep LIFO attached.
module tb_lifo_port_ctrl;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;
    localparam int DEPTH  = 8;

    logic clk;
    logic nrst;
    int   n_tests;
    int   n_fail;
    int   collisions;

    lifo_port_ctrl_if #(.DATA_W(DATA_W), .STAT_W(STAT_W)) bus ();

    lifo_port_ctrl #(.DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    // Behavioural LIFO
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [3:0]        cnt;
    logic [2:0]        top_idx;
    assign top_idx         = 3'(cnt - 4'd1);
    assign bus.lifo_empty  = (cnt == 4'd0);
    assign bus.lifo_full   = (cnt == 4'(DEPTH));
    assign bus.lifo_r_data = (cnt != 4'd0) ? mem[top_idx] : '0;

    initial cnt = 4'd0;
    always @(posedge clk) begin
        if (bus.lifo_w_req && cnt < 4'(DEPTH)) begin
            mem[cnt[2:0]] <= bus.lifo_w_data;
            cnt <= cnt + 4'd1;
        end else if (bus.lifo_r_req && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    initial collisions = 0;
    always @(posedge clk) begin
        if (bus.lifo_w_req && bus.lifo_r_req) collisions <= collisions + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        bus.flush = 1'b0;
        cyc();
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_valid=%b m_data=%0h busy=%b, want 0 0 0",
                     bus.m_valid, bus.m_data, bus.busy);
        end
        n_tests++;
        if (bus.push_cnt !== 16'h0 || bus.pop_cnt !== 16'h0 ||
            bus.lifo_w_req !== 1'b0 || bus.lifo_r_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt_req: push=%0d pop=%0d w=%b r=%b, want all 0",
                     bus.push_cnt, bus.pop_cnt, bus.lifo_w_req, bus.lifo_r_req);
        end
        @(posedge clk);
        #1 nrst = 1'b1;
        #1;
        // Load a word into the output register, then drop reset between edges.
        bus.s_valid = 1'b1;
        bus.s_data = 32'h5A;
        cyc();
        bus.s_valid = 1'b0;
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h5A) begin
            n_fail++;
            $display("FAIL reset_preload: m_valid=%b m_data=%0h, want 1 5a",
                     bus.m_valid, bus.m_data);
        end
        #2 nrst = 1'b0;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: m_valid=%b m_data=%0h busy=%b, want 0 0 0",
                     bus.m_valid, bus.m_data, bus.busy);
        end
        @(posedge clk);
        #1 nrst = 1'b1;
        #1;
    endtask

    task automatic test_bypass();
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 32'hA1;
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b1 || bus.lifo_w_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_accept: s_ready=%b w_req=%b, want 1 0",
                     bus.s_ready, bus.lifo_w_req);
        end
        cyc();
        bus.s_valid = 1'b0;
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA1) begin
            n_fail++;
            $display("FAIL bypass_data: m_valid=%b m_data=%0h, want 1 a1",
                     bus.m_valid, bus.m_data);
        end
        cyc();
        n_tests++;
        if (bus.m_valid !== 1'b0 || cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL bypass_idle: m_valid=%b lifo_cnt=%0d, want 0 0", bus.m_valid, cnt);
        end
    endtask

    task automatic test_stack_order();
        logic [STAT_W-1:0] exp_pop;
        logic [STAT_W-1:0] exp_push;
`ifdef LIFO_PORT_CTRL_STATS_EN
        exp_pop  = 16'd3;
        exp_push = 16'd3;
`else
        exp_pop  = 16'd0;
        exp_push = 16'd0;
`endif
        do_reset();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 32'h11;
        cyc();
        bus.s_data = 32'h22;
        #1;
        n_tests++;
        if (bus.lifo_w_req !== 1'b1 || bus.lifo_w_data !== 32'h22 || bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL order_write: w_req=%b w_data=%0h s_ready=%b, want 1 22 1",
                     bus.lifo_w_req, bus.lifo_w_data, bus.s_ready);
        end
        cyc();
        bus.s_data = 32'h33;
        cyc();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h11) begin
            n_fail++;
            $display("FAIL order_first: m_valid=%b m_data=%0h, want 1 11", bus.m_valid, bus.m_data);
        end
        cyc();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h33) begin
            n_fail++;
            $display("FAIL order_second: m_valid=%b m_data=%0h, want 1 33", bus.m_valid, bus.m_data);
        end
        cyc();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h22) begin
            n_fail++;
            $display("FAIL order_third: m_valid=%b m_data=%0h, want 1 22", bus.m_valid, bus.m_data);
        end
        cyc();
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.pop_cnt !== exp_pop || bus.push_cnt !== exp_push) begin
            n_fail++;
            $display("FAIL order_counts: m_valid=%b pop_cnt=%0d push_cnt=%0d, want 0 %0d %0d",
                     bus.m_valid, bus.pop_cnt, bus.push_cnt, exp_pop, exp_push);
        end
    endtask

    task automatic test_full();
        int bad;
        logic [DATA_W-1:0] exp;
        bad = 0;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 32'h100;
        cyc();
        for (int i = 1; i <= DEPTH; i++) begin
            bus.s_data = 32'h100 + 32'(i);
            #1;
            if (bus.s_ready !== 1'b1) bad++;
            cyc();
        end
        n_tests++;
        if (bad != 0 || cnt !== 4'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_fill: refused=%0d lifo_cnt=%0d, want 0 %0d", bad, cnt, DEPTH);
        end
        bus.s_data = 32'h1FF;
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b0 || bus.lifo_w_req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_backpressure: s_ready=%b w_req=%b, want 0 0",
                     bus.s_ready, bus.lifo_w_req);
        end
        cyc();
        cyc();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        bad = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            exp = (i == 0) ? 32'h100 : 32'h100 + 32'(DEPTH + 1 - i);
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp) bad++;
            cyc();
        end
        n_tests++;
        if (bad != 0 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: wrong_words=%0d m_valid=%b, want 0 0", bad, bus.m_valid);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        int bad;
        logic [STAT_W-1:0] pop_before;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.s_data = 32'h200 + 32'(i);
            cyc();
        end
        bus.s_valid = 1'b0;
        n_tests++;
        if (cnt !== 4'd5 || bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: lifo_cnt=%0d m_valid=%b, want 5 1", cnt, bus.m_valid);
        end
        pop_before = bus.pop_cnt;
        bus.flush = 1'b1;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 32'h2FF;
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b0 || bus.lifo_w_req !== 1'b0 || bus.lifo_r_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: s_ready=%b w_req=%b r_req=%b, want 0 0 0",
                     bus.s_ready, bus.lifo_w_req, bus.lifo_r_req);
        end
        cyc();
        bus.flush = 1'b0;
        bus.s_valid = 1'b0;
        busy_cycles = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy !== 1'b1) break;
            busy_cycles++;
            bus.flush = (i == 2);
            #1;
            if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) bad++;
            cyc();
            bus.flush = 1'b0;
        end
        n_tests++;
        if (busy_cycles != 6 || bad != 0) begin
            n_fail++;
            $display("FAIL flush_busy: busy_cycles=%0d violations=%0d, want 6 0", busy_cycles, bad);
        end
        n_tests++;
        if (bus.lifo_empty !== 1'b1 || bus.m_valid !== 1'b0 || bus.pop_cnt !== pop_before) begin
            n_fail++;
            $display("FAIL flush_end: empty=%b m_valid=%b pop_cnt=%0d, want 1 0 %0d",
                     bus.lifo_empty, bus.m_valid, bus.pop_cnt, pop_before);
        end
        bus.s_valid = 1'b1;
        bus.s_data = 32'h300;
        cyc();
        bus.s_valid = 1'b0;
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_resume: m_valid=%b m_data=%0h, want 1 300", bus.m_valid, bus.m_data);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] sb[$];
        logic [DATA_W-1:0] id;
        logic [DATA_W-1:0] exp;
        logic acc;
        logic ld;
        int coll;
        int order_err;
        int n_acc;
        int n_del;
        coll = 0;
        order_err = 0;
        n_acc = 0;
        n_del = 0;
        id = 32'h1000;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        cyc();
        for (int i = 0; i < 10040; i++) begin
            if (i < 10000) begin
                bus.s_valid = ($urandom_range(0, 9) < 6);
                bus.m_ready = ($urandom_range(0, 9) < 4);
            end else begin
                bus.s_valid = 1'b0;
                bus.m_ready = 1'b1;
            end
            bus.s_data = id;
            #1;
            acc = bus.s_valid & bus.s_ready;
            ld = ~bus.m_valid | bus.m_ready;
            if (bus.m_valid && bus.m_ready) n_del++;
            if (bus.lifo_w_req && bus.lifo_r_req) coll++;
            cyc();
            if (acc) begin
                sb.push_back(id);
                id = id + 32'd1;
                n_acc++;
            end
            if (ld && bus.m_valid) begin
                if (sb.size() == 0) begin
                    order_err++;
                end else begin
                    exp = sb.pop_back();
                    if (bus.m_data !== exp) order_err++;
                end
            end
        end
        n_tests++;
        if (coll != 0 || collisions != 0) begin
            n_fail++;
            $display("FAIL random_collision: local=%0d global=%0d, want 0 0", coll, collisions);
        end
        n_tests++;
        if (order_err != 0) begin
            n_fail++;
            $display("FAIL random_order: order_errors=%0d, want 0", order_err);
        end
        n_tests++;
        if (sb.size() != 0 || n_del != n_acc || bus.m_valid !== 1'b0 || n_acc < 100) begin
            n_fail++;
            $display("FAIL random_lost: pending=%0d delivered=%0d accepted=%0d m_valid=%b, want 0 equal 0",
                     sb.size(), n_del, n_acc, bus.m_valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_bypass();
        test_stack_order();
        test_full();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lifo_port_ctrl.md
Name: lifo_port_ctrl

Overview:
Upstream/downstream port controller for the single-clock LIFO stack. Converts a valid/ready push stream into LIFO write requests and drains the stack into a registered valid/ready pop stream. Never issues simultaneous write and read to the LIFO, so the LIFO's write-and-read-at-zero-count corner case cannot occur. Adds a bypass path (newest word goes straight to output), a flush/drain sequencer and optional statistics.

Parameters:
DATA_W, 32, data word width; must match LIFO DATA_W
STAT_W, 16, width of optional statistics counters

Ports:
clk  input  1  system clock
nrst  input  1  reset; one clock; reset is asynchronous and active-low
s_valid  input  1  push word valid
s_data  input  DATA_W  push word
s_ready  output  1  push word accepted when s_valid & s_ready
m_valid  output  1  pop output register valid
m_data  output  DATA_W  pop output register data
m_ready  input  1  consumer takes m_data when m_valid & m_ready
flush  input  1  single-cycle pulse: discard output register and drain LIFO
busy  output  1  high while draining
lifo_w_req  output  1  to LIFO w_req
lifo_w_data  output  DATA_W  to LIFO w_data
lifo_r_req  output  1  to LIFO r_req
lifo_r_data  input  DATA_W  LIFO top-of-stack word, valid combinationally when lifo_empty=0
lifo_empty  input  1  from LIFO
lifo_full  input  1  from LIFO
push_cnt  output  STAT_W  accepted pushes (optional feature)
pop_cnt  output  STAT_W  delivered pops (optional feature)

Behaviour:
- Reset (nrst=0, async): state RUN, m_valid=0, m_data=0, busy=0, push_cnt=pop_cnt=0. Outputs lifo_w_req/lifo_r_req are combinational; they are 0 during reset.
- States: RUN, DRAIN.
- RUN: load = ~m_valid | m_ready (output register free or emptying this cycle).
  - load & s_valid: bypass; m_data<=s_data, m_valid<=1, s_ready=1, no LIFO access. Newest word is top of stack.
  - load & ~s_valid & ~lifo_empty: lifo_r_req=1, m_data<=lifo_r_data, m_valid<=1.
  - load & ~s_valid & lifo_empty: m_valid<=0.
  - ~load & s_valid & ~lifo_full: lifo_w_req=1, lifo_w_data=s_data, s_ready=1.
  - ~load & lifo_full: s_ready=0.
  - Invariant: lifo_w_req & lifo_r_req never both 1.
  - A word in the output register is committed; later pushes do not displace it.
- s_ready depends on m_ready, lifo_full and state only, never on s_valid.
- flush in RUN: next cycle state=DRAIN, m_valid=0, busy=1. A push or pop handshake in the flush cycle is ignored: s_ready=0, lifo_w_req=0, lifo_r_req=0, and m_valid & m_ready does not count as delivered.
- DRAIN: s_ready=0, m_valid=0, lifo_w_req=0, lifo_r_req=~lifo_empty each cycle. The state returns to RUN in the cycle after lifo_empty=1 is sampled; busy=0 in RUN. flush during DRAIN has no effect.
- Latency: push to m_valid by bypass is 1 cycle. Pop from LIFO to m_valid is 1 cycle after load.
- Reset mid-drain or mid-transfer: immediate return to the reset values above. LIFO contents are not touched by this block.

Optional Feature:
LIFO_PORT_CTRL_STATS_EN
- Defined: push_cnt increments on each s_valid & s_ready. pop_cnt increments on each m_valid & m_ready. Both saturate at all-ones and clear only on reset. Bypass counts as both a push and, when consumed, a pop.
- Undefined: push_cnt and pop_cnt tied to 0, no counter flops.

Test Plan:
- Reset mid-stream: nrst low with m_valid=1 -> m_valid=0, m_data=0, busy=0 asynchronously, with no clock edge required.
- Bypass: m_ready=1, LIFO empty, push 0xA1 -> m_valid=1 and m_data=0xA1 next cycle; lifo_w_req never asserted.
- Stack order: m_ready=0, push 0x11, then push 0x22 and 0x33, then m_ready=1 -> 0x11 is delivered first (committed in the output register), then 0x33, 0x22; pop_cnt=3.
- Full backpressure: m_valid=1, m_ready=0, push until lifo_full=1 -> s_ready=0. No lifo_w_req while full; the extra word is held by the source.
- Collision avoidance: random s_valid/m_ready for 10k cycles -> lifo_w_req & lifo_r_req never both 1. Scoreboard shows LIFO order with zero lost words.
- Flush: LIFO holds 5 words, m_valid=1, pulse flush -> busy=1 for 6 cycles (5 pops plus the empty-check cycle). m_valid=0 throughout, s_ready=0, then RUN with lifo_empty=1.
